uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 39 +++
 rtl/uart_tx_engine.sv | 139 +++++++++++++
 tb/tb_uart_tx_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: transmit FSM state encoding and the
//               default baud/frame constants used by the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int c_DEFAULT_CLKS_PER_BIT = 868;
    localparam int c_DEFAULT_WIDTH        = 8;

    // Transmit frame sequencing; PARITY is only visited when parity is enabled
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Per-bit cycle counter. Counts 0..CLKS_PER_BIT-1 while enabled,
//               wraps automatically, and flags the last cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: restarts on clear, wraps after the last cycle of a bit
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == c_LAST);

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmitter fed directly from a FIFO. Pops one word per
//               frame, sends start, data (LSB first), optional parity and stop
//               bits, and chains frames back-to-back while data is available.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH        = c_DEFAULT_WIDTH,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                 c_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
    localparam logic               c_PAR_EN   = (PARITY_EN != 0);
    localparam logic               c_PAR_ODD  = (PARITY_ODD != 0);

    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     w_shift_next;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_fifo_read;
    logic                 w_baud_last;
    // Cycle count is exposed by the counter for observability; the FSM only
    // needs the last-cycle flag.
    logic [c_CNT_W-1:0]   w_cnt_unused;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (CLK),
        .rst      (RST),
        .i_clear  (w_fifo_read),
        .i_enable (r_state != IDLE),
        .o_count  (w_cnt_unused),
        .o_last   (w_baud_last)
    );

    // Next-state, datapath and line-level decode; a pop always restarts a frame
    always_comb begin
        w_fifo_read    = !RST && !fifo_empty &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_parity_next  = r_parity;
        w_tx_next      = 1'b1;

        if (w_fifo_read) begin
            w_state_next   = START;
            w_shift_next   = fifo_data;
            w_bit_idx_next = '0;
            // Parity is taken from the whole word before it is shifted out
            w_parity_next  = (^fifo_data) ^ c_PAR_ODD;
        end else begin
            case (r_state)
                START: begin
                    if (w_baud_last) begin
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        if (r_bit_idx == c_LAST_IDX) begin
                            w_state_next = c_PAR_EN ? PARITY : STOP;
                        end else begin
                            w_bit_idx_next = r_bit_idx + c_IDX_W'(1);
                            w_shift_next   = r_shift >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_baud_last) begin
                        w_state_next = STOP;
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        // tx is registered, so decode the level the line takes in the next state
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    assign fifo_read = w_fifo_read;
    assign tx        = r_tx;
    assign busy      = (r_state != IDLE);

endmodule : uart_tx_engine
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Directed self-checking bench for uart_tx_engine with
//               CLKS_PER_BIT=4, WIDTH=8; one instance without parity, and
//               even/odd parity instances sharing their own FIFO inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int c_CPB = 4;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx;
    logic       busy;

    logic       fifo_empty_p;
    logic [7:0] fifo_data_p;
    logic       fifo_read_e, tx_e, busy_e;
    logic       fifo_read_o, tx_o, busy_o;

    logic [7:0] q[$];

    logic [127:0] tx_v, busy_v, rd_v;
    logic [127:0] txe_v, txo_v, busye_v, busyo_v, rde_v, rdo_v;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_engine #(
        .CLKS_PER_BIT (c_CPB), .WIDTH (8), .PARITY_EN (0), .PARITY_ODD (0)
    ) u_dut (
        .CLK (clk), .RST (rst), .fifo_empty (fifo_empty), .fifo_data (fifo_data),
        .fifo_read (fifo_read), .tx (tx), .busy (busy)
    );

    uart_tx_engine #(
        .CLKS_PER_BIT (c_CPB), .WIDTH (8), .PARITY_EN (1), .PARITY_ODD (0)
    ) u_dut_even (
        .CLK (clk), .RST (rst), .fifo_empty (fifo_empty_p), .fifo_data (fifo_data_p),
        .fifo_read (fifo_read_e), .tx (tx_e), .busy (busy_e)
    );

    uart_tx_engine #(
        .CLKS_PER_BIT (c_CPB), .WIDTH (8), .PARITY_EN (1), .PARITY_ODD (1)
    ) u_dut_odd (
        .CLK (clk), .RST (rst), .fifo_empty (fifo_empty_p), .fifo_data (fifo_data_p),
        .fifo_read (fifo_read_o), .tx (tx_o), .busy (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ones(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] span(input int off, input int len);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[off + i] = 1'b1;
        return v;
    endfunction

    // Overlay one serial frame (start, 8 data LSB first, optional parity, stop)
    function automatic logic [127:0] put_frame(input logic [127:0] base, input int off,
                                               input logic [7:0] d, input bit pe, input bit odd);
        logic [127:0] v;
        logic         b;
        int           nb;
        v  = base;
        nb = pe ? 11 : 10;
        for (int k = 0; k < nb; k++) begin
            if (k == 0)             b = 1'b0;
            else if (k <= 8)        b = d[k-1];
            else if (pe && k == 9)  b = (^d) ^ odd;
            else                    b = 1'b1;
            for (int c = 0; c < c_CPB; c++) v[off + k*c_CPB + c] = b;
        end
        return v;
    endfunction

    task automatic refresh_fifo();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        refresh_fifo();
    endtask

    // Sample all outputs mid-cycle for n cycles; pop the FIFO models on reads
    task automatic capture(input int n);
        tx_v = '0; busy_v = '0; rd_v = '0;
        txe_v = '0; txo_v = '0; busye_v = '0; busyo_v = '0; rde_v = '0; rdo_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_v[i]    = tx;     busy_v[i]  = busy;   rd_v[i]  = fifo_read;
            txe_v[i]   = tx_e;   busye_v[i] = busy_e; rde_v[i] = fifo_read_e;
            txo_v[i]   = tx_o;   busyo_v[i] = busy_o; rdo_v[i] = fifo_read_o;
            @(posedge clk);
            #1;
            if (rd_v[i] && q.size() > 0) begin
                void'(q.pop_front());
                refresh_fifo();
            end
            if (rde_v[i]) fifo_empty_p = 1'b1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        fifo_empty   = 1'b1;
        fifo_data    = 8'h00;
        fifo_empty_p = 1'b1;
        fifo_data_p  = 8'h07;
        push(8'h55);
        @(posedge clk);
        #1;

        // Reset held with data waiting: line idle, no pop
        capture(3);
        check("rst_tx",   tx_v,   ones(3));
        check("rst_busy", busy_v, '0);
        check("rst_read", rd_v,   '0);

        // Single 0x55 frame, fetched on the first cycle after reset
        rst = 1'b0;
        capture(44);
        check("f55_tx",   tx_v,   put_frame(ones(44), 1, 8'h55, 1'b0, 1'b0));
        check("f55_busy", busy_v, span(1, 40));
        check("f55_read", rd_v,   128'h1);

        // Back-to-back 0xA5, 0x3C
        push(8'hA5);
        push(8'h3C);
        capture(84);
        check("b2b_tx",   tx_v,   put_frame(put_frame(ones(84), 1, 8'hA5, 1'b0, 1'b0),
                                            41, 8'h3C, 1'b0, 1'b0));
        check("b2b_busy", busy_v, span(1, 80));
        check("b2b_read", rd_v,   span(0, 1) | span(40, 1));

        // Parity frames of 0x07 on the even and odd instances
        fifo_empty_p = 1'b0;
        capture(48);
        check("par_even_tx",   txe_v,   put_frame(ones(48), 1, 8'h07, 1'b1, 1'b0));
        check("par_odd_tx",    txo_v,   put_frame(ones(48), 1, 8'h07, 1'b1, 1'b1));
        check("par_even_busy", busye_v, span(1, 44));
        check("par_odd_busy",  busyo_v, span(1, 44));
        check("par_even_read", rde_v,   128'h1);
        check("par_odd_read",  rdo_v,   128'h1);
        check("par_plain_idle", tx_v,   ones(48));

        // Reset during data bit 3 of 0xC3, with 0x96 still queued
        push(8'hC3);
        push(8'h96);
        capture(18);
        check("mid_pre_tx",   tx_v, put_frame(ones(128), 1, 8'hC3, 1'b0, 1'b0) & ones(18));
        check("mid_pre_read", rd_v, 128'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_read", {127'd0, fifo_read}, 128'h0);
        check("mid_rst_busy", {127'd0, busy},      128'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        capture(44);
        check("mid_post_tx0",   {127'd0, tx_v[0]},   128'h1);
        check("mid_post_busy0", {127'd0, busy_v[0]}, 128'h0);
        check("mid_post_tx",    tx_v,   put_frame(ones(44), 1, 8'h96, 1'b0, 1'b0));
        check("mid_post_busy",  busy_v, span(1, 40));
        check("mid_post_read",  rd_v,   128'h1);

        // Empty FIFO for 100 cycles: nothing happens
        capture(100);
        check("idle_tx",   tx_v,   ones(100));
        check("idle_busy", busy_v, '0);
        check("idle_read", rd_v,   '0);
        check("idle_read_par", rde_v | rdo_v, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_engine
`default_nettype wire
